// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared tags, L1A info field positions and FSM states for the DAQ frame builder
package daq_pkg;

    localparam logic [3:0] TAG_H0H1 = 4'hA;
    localparam logic [3:0] TAG_H2   = 4'hB;
    localparam logic [3:0] TAG_H3   = 4'hC;
    localparam logic [3:0] TAG_H4   = 4'hD;
    localparam logic [3:0] TAG_T0   = 4'hE;
    localparam logic [3:0] TAG_T1   = 4'hF;

    localparam int L1ACNT_LSB     = 0;
    localparam int L1AMCNT_LSB    = 24;
    localparam int OVCNT_LSB      = 36;
    localparam int L1A_MATCH_BIT  = 40;
    localparam int L1A_PHASE_BIT  = 41;
    localparam int OVRLAP_BIT     = 42;
    localparam int MULTI_OVLP_BIT = 43;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INFO_RD  = 3'd1;
    localparam logic [2:0] ST_INFO_CAP = 3'd2;
    localparam logic [2:0] ST_HDR      = 3'd3;
    localparam logic [2:0] ST_CH_RD    = 3'd4;
    localparam logic [2:0] ST_CH_CAP   = 3'd5;
    localparam logic [2:0] ST_TRL      = 3'd6;

    function automatic logic [15:0] hdr_word(input logic [2:0]  idx,
                                             input logic [43:0] info,
                                             input logic [6:0]  smax);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {TAG_H0H1, info[L1ACNT_LSB + 12 +: 12]};
            3'd1:    w = {TAG_H0H1, info[L1ACNT_LSB +: 12]};
            3'd2:    w = {TAG_H2, info[L1AMCNT_LSB +: 12]};
            3'd3:    w = {TAG_H3, 5'b0, smax};
            default: w = {TAG_H4, 4'b0, info[MULTI_OVLP_BIT], info[OVRLAP_BIT],
                          info[L1A_PHASE_BIT], info[L1A_MATCH_BIT], info[OVCNT_LSB +: 4]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/daq_out_slot.sv
// rtl/daq_out_slot.sv - single valid/ready output register with frame checksum and data-word count
module daq_out_slot (
    input  logic        CLK40,
    input  logic        srst,
    input  logic        clr,
    input  logic        load,
    input  logic        is_data,
    input  logic [15:0] ld_data,
    input  logic        ld_sof,
    input  logic        ld_eof,
    input  logic        out_rdy,
    output logic        slot_free,
    output logic [15:0] out_data,
    output logic        out_vld,
    output logic        out_sof,
    output logic        out_eof,
    output logic [11:0] cks,
    output logic [11:0] wc
);

    logic        vld_q, vld_d;
    logic [15:0] data_q, data_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [11:0] cks_q, cks_d;
    logic [11:0] wc_q, wc_d;

    assign slot_free = !vld_q || out_rdy;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        sof_d  = sof_q;
        eof_d  = eof_q;
        cks_d  = cks_q;
        wc_d   = wc_q;
        if (clr) begin
            cks_d = '0;
            wc_d  = '0;
        end
        // Callers only assert load when slot_free, so a stalled word is never overwritten.
        if (load) begin
            vld_d  = 1'b1;
            data_d = ld_data;
            sof_d  = ld_sof;
            eof_d  = ld_eof;
            cks_d  = cks_q ^ ld_data[11:0];
            if (is_data) begin
                wc_d = wc_q + 12'd1;
            end
        end else if (out_rdy) begin
            vld_d = 1'b0;
            sof_d = 1'b0;
            eof_d = 1'b0;
        end
    end

    always_ff @(posedge CLK40 or posedge srst) begin
        if (srst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            cks_q  <= '0;
            wc_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            sof_q  <= sof_d;
            eof_q  <= eof_d;
            cks_q  <= cks_d;
            wc_q   <= wc_d;
        end
    end

    assign out_data = data_q;
    assign out_vld  = vld_q;
    assign out_sof  = sof_q;
    assign out_eof  = eof_q;
    assign cks      = cks_q;
    assign wc       = wc_q;

endmodule

// File: rtl/daq_frame_builder.sv
// rtl/daq_frame_builder.sv - drains L1A info and channel FIFOs into a framed 16-bit word stream
module daq_frame_builder
    import daq_pkg::*;
#(
    parameter int NCH       = 16,
    parameter int HDR_WORDS = 5
) (
    input  logic              CLK40,
    input  logic              srst,
    input  logic              RDY,
    input  logic [43:0]       L1A_SMP_OUT,
    input  logic [12*NCH-1:0] DOUT_16CH,
    input  logic [NCH-1:0]    CH_EMPTY,
    input  logic [6:0]        SAMP_MAX,
    input  logic              OUT_RDY,
    output logic              L1A_RD_EN,
    output logic [NCH-1:0]    RD_ENA,
    output logic [15:0]       OUT_DATA,
    output logic              OUT_VLD,
    output logic              OUT_SOF,
    output logic              OUT_EOF,
    output logic              BUSY,
    output logic              UNDERFLOW
);

    localparam logic [3:0] CH_LAST  = 4'(NCH - 1);
    localparam logic [2:0] HDR_LAST = 3'(HDR_WORDS - 1);

    logic [2:0]  state_q, state_d;
    logic [6:0]  smax_q, smax_d;
    logic [43:0] info_q, info_d;
    logic [2:0]  hidx_q, hidx_d;
    logic [3:0]  ch_q, ch_d;
    logic [6:0]  smp_q, smp_d;
    logic        tidx_q, tidx_d;
    logic        underflow_q, underflow_d;

    logic        slot_free;
    logic        clr, load, is_data, ld_sof, ld_eof, adv;
    logic [15:0] ld_data;
    logic [11:0] cks, wc;
    logic [11:0] ch_word;

    assign ch_word = DOUT_16CH[12*ch_q +: 12];

    always_comb begin
        state_d     = state_q;
        smax_d      = smax_q;
        info_d      = info_q;
        hidx_d      = hidx_q;
        ch_d        = ch_q;
        smp_d       = smp_q;
        tidx_d      = tidx_q;
        underflow_d = underflow_q;
        clr         = 1'b0;
        load        = 1'b0;
        is_data     = 1'b0;
        ld_data     = '0;
        ld_sof      = 1'b0;
        ld_eof      = 1'b0;
        adv         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                smax_d = SAMP_MAX;
                if (RDY) begin
                    state_d = ST_INFO_RD;
                    clr     = 1'b1;
                end
            end
            ST_INFO_RD: state_d = ST_INFO_CAP;
            ST_INFO_CAP: begin
                info_d  = L1A_SMP_OUT;
                hidx_d  = '0;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                if (slot_free) begin
                    load    = 1'b1;
                    ld_data = hdr_word(hidx_q, info_q, smax_q);
                    ld_sof  = (hidx_q == 3'd0);
                    if (hidx_q == HDR_LAST) begin
                        hidx_d  = '0;
                        ch_d    = '0;
                        smp_d   = '0;
                        state_d = ST_CH_RD;
                    end else begin
                        hidx_d = hidx_q + 3'd1;
                    end
                end
            end
            ST_CH_RD: begin
                // The read is issued regardless of the slot; the FIFO output holds until captured.
                if (!CH_EMPTY[ch_q]) begin
                    state_d = ST_CH_CAP;
                end else if (slot_free) begin
                    load        = 1'b1;
                    is_data     = 1'b1;
                    ld_data     = {ch_q, 12'hFFF};
                    underflow_d = 1'b1;
                    adv         = 1'b1;
                end
            end
            ST_CH_CAP: begin
                if (slot_free) begin
                    load    = 1'b1;
                    is_data = 1'b1;
                    ld_data = {ch_q, ch_word};
                    adv     = 1'b1;
                end
            end
            ST_TRL: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (!tidx_q) begin
                        ld_data = {TAG_T0, wc};
                        tidx_d  = 1'b1;
                    end else begin
                        ld_data = {TAG_T1, cks};
                        ld_eof  = 1'b1;
                        tidx_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (adv) begin
            if (smp_q == smax_q) begin
                smp_d = '0;
                if (ch_q == CH_LAST) begin
                    ch_d    = '0;
                    tidx_d  = 1'b0;
                    state_d = ST_TRL;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    state_d = ST_CH_RD;
                end
            end else begin
                smp_d   = smp_q + 7'd1;
                state_d = ST_CH_RD;
            end
        end
    end

    always_ff @(posedge CLK40 or posedge srst) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            smax_q      <= '0;
            info_q      <= '0;
            hidx_q      <= '0;
            ch_q        <= '0;
            smp_q       <= '0;
            tidx_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            smax_q      <= smax_d;
            info_q      <= info_d;
            hidx_q      <= hidx_d;
            ch_q        <= ch_d;
            smp_q       <= smp_d;
            tidx_q      <= tidx_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        RD_ENA = '0;
        if (state_q == ST_CH_RD && !CH_EMPTY[ch_q]) begin
            RD_ENA[ch_q] = 1'b1;
        end
    end

    assign L1A_RD_EN = (state_q == ST_INFO_RD);
    assign BUSY      = (state_q != ST_IDLE);
    assign UNDERFLOW = underflow_q;

    daq_out_slot u_out_slot (
        .CLK40     (CLK40),
        .srst      (srst),
        .clr       (clr),
        .load      (load),
        .is_data   (is_data),
        .ld_data   (ld_data),
        .ld_sof    (ld_sof),
        .ld_eof    (ld_eof),
        .out_rdy   (OUT_RDY),
        .slot_free (slot_free),
        .out_data  (OUT_DATA),
        .out_vld   (OUT_VLD),
        .out_sof   (OUT_SOF),
        .out_eof   (OUT_EOF),
        .cks       (cks),
        .wc        (wc)
    );

endmodule

// File: doc/daq_frame_builder.md
Name: daq_frame_builder

Overview:
- Readout stage directly downstream of the 16-channel DAQ sample FIFO bank and its L1A/sample-info FIFO.
- When an event is ready, pops one 44-bit L1A info word, then drains each channel FIFO in channel-major order: channel 0 samples 0..SAMP_MAX, then channel 1, and so on.
- Serialises the event into a 16-bit framed word stream (header, data, trailer) with valid/ready backpressure toward the optical link formatter.

Parameters:
- NCH, 16, number of ADC channels; fixes RD_ENA width and the 4-bit channel tag.
- HDR_WORDS, 5, number of header words (fixed layout below; parameter only documents it).

Ports:
- CLK40  input  1  readout clock; also used as the FIFO read clock.
- srst  input  1  asynchronous, active-high reset.
- RDY  input  1  L1A info FIFO not empty.
- L1A_SMP_OUT  input  44  info word: [43] multi_ovlp, [42] ovrlap, [41] l1a_phase, [40] l1a_match, [39:36] ovrlap_cnt, [35:24] l1amcnt, [23:0] l1acnt.
- DOUT_16CH  input  192  channel FIFO outputs; channel c is bits [12c+11:12c].
- CH_EMPTY  input  16  per-channel FIFO empty flags.
- SAMP_MAX  input  7  samples per event minus 1.
- OUT_RDY  input  1  downstream accepts OUT_DATA this cycle.
- L1A_RD_EN  output  1  one-cycle pop of the info FIFO.
- RD_ENA  output  16  one-hot, one-cycle pop of one channel FIFO.
- OUT_DATA  output  16  frame word.
- OUT_VLD  output  1  OUT_DATA valid.
- OUT_SOF  output  1  qualifies the first header word.
- OUT_EOF  output  1  qualifies the last trailer word.
- BUSY  output  1  frame in progress (state != IDLE).
- UNDERFLOW  output  1  sticky; set when a channel read was required while that channel's FIFO was empty.

Behaviour:
- FIFO read model: standard (non-FWFT), 1-cycle read latency. Data is valid in the cycle after RD_EN and holds until the next read.
- Reset values: all outputs 0; state IDLE; all counters and the checksum 0.
- Output slot: a single output register.
  - slot_free = !OUT_VLD | OUT_RDY.
  - A word is loaded only when slot_free.
  - OUT_DATA, OUT_SOF and OUT_EOF are held stable while OUT_VLD & !OUT_RDY.
- State machine:
  - IDLE: if RDY, go to INFO_RD. Latch smax <= SAMP_MAX here; this value is used for the whole frame.
  - INFO_RD: L1A_RD_EN=1 for exactly one cycle, then INFO_CAP.
  - INFO_CAP: capture L1A_SMP_OUT into info register, then HDR.
  - HDR: emit 5 words, one per slot_free cycle; OUT_SOF=1 on H0.
    - H0 = {4'hA, l1acnt[23:12]}
    - H1 = {4'hA, l1acnt[11:0]}
    - H2 = {4'hB, l1amcnt}
    - H3 = {4'hC, 5'b0, smax}
    - H4 = {4'hD, 4'b0, multi_ovlp, ovrlap, l1a_phase, l1a_match, ovrlap_cnt}
    - After H4, go to CH_RD with ch=0, smp=0.
  - CH_RD: entered only when slot_free.
    - If CH_EMPTY[ch]=0: RD_ENA[ch]=1 for one cycle, then CH_CAP.
    - If CH_EMPTY[ch]=1: no read; set UNDERFLOW; load word {ch, 12'hFFF} directly, then advance.
  - CH_CAP: wait for slot_free, then load {ch, DOUT_16CH[12ch+11:12ch]} and advance.
  - Advance rule: if smp==smax, set smp=0 and ch=ch+1; otherwise smp=smp+1. After ch=NCH-1 and smp=smax, go to TRL.
  - TRL: emit two words, then IDLE.
    - T0 = {4'hE, wc[11:0]}, where wc = count of data words = NCH*(smax+1), max 2048.
    - T1 = {4'hF, cks[11:0]} with OUT_EOF=1. cks = XOR of bits [11:0] of every prior word in the frame (H0..T0).
- Throughput: at most one data word every 2 cycles. wc and cks clear on entry to INFO_RD.
- Simultaneous events:
  - RDY is sampled only in IDLE. A new RDY during a frame waits; back-to-back frames need no idle gap beyond one IDLE cycle.
  - SAMP_MAX changes mid-frame have no effect.
- srst mid-frame: immediate return to IDLE, frame truncated, OUT_VLD=0. The FIFOs are not flushed; upstream RST_RESYNC is used for that.
- UNDERFLOW clears only on srst.

Decomposition:
- Shared package daq_pkg holds:
  - header/trailer tag constants: TAG_H0H1=4'hA, TAG_H2=4'hB, TAG_H3=4'hC, TAG_H4=4'hD, TAG_T0=4'hE, TAG_T1=4'hF;
  - L1A info field bit positions;
  - the state enum.
- One natural sub-module: daq_out_slot, the valid/ready output register plus checksum/word-count accumulator.

Test Plan:
- SAMP_MAX=7, all FIFOs preloaded with ch*16+s, info word l1acnt=24'h123456, l1amcnt=12'h0AB, OUT_RDY=1 -> stream:
  - header 16'hA123, 16'hA456, 16'hB0AB, 16'hC007, H4;
  - 128 data words {ch, ch*16+s} in channel-major order;
  - T0=16'hE080, T1 checksum matching the model;
  - one SOF and one EOF; exactly 128 RD_ENA pulses and 1 L1A_RD_EN.
- Same frame with OUT_RDY toggling at random (50%) -> identical word sequence; no word dropped or duplicated; OUT_DATA stable while stalled.
- CH_EMPTY[5]=1 throughout, SAMP_MAX=0 -> channel-5 word is 16'h5FFF; RD_ENA[5] never asserted; UNDERFLOW=1 until srst.
- Two info words queued, SAMP_MAX=127 -> two complete frames back to back, each with T0=16'hE800; SAMP_MAX changed to 3 mid-frame has no effect.
- srst asserted during data phase at ch=3 -> next cycle all outputs 0 and state IDLE; the next RDY starts a fresh frame with SOF on H0.
